// File: rtl/config_stim_driver.sv
// Configuration and stimulus sequencer for a fabric under test.
// Shifts a bitstream into the config chain, reads it back, and then
// applies test vectors with a settle gap and a check strobe per vector.
module config_stim_driver #(
  parameter int DATA_IN_WIRE_WIDTH  = 8,
  parameter int DATA_OUT_WIRE_WIDTH = 8,
  parameter int CONFIG_WIDTH        = 64,
  parameter int NUM_VECTORS         = 16,
  parameter int SETTLE_CYCLES       = 2
) (
  input  logic                                                  clk,
  input  logic                                                  resetn,
  input  logic                                                  start,
  output logic [$clog2(CONFIG_WIDTH)-1:0]                       cfg_bit_addr,
  input  logic                                                  cfg_bit_data,
  output logic [((NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1)-1:0] vec_addr,
  input  logic [DATA_IN_WIRE_WIDTH-1:0]                         vec_datain,
  input  logic [DATA_OUT_WIRE_WIDTH-1:0]                        vec_expected,
  output logic                                                  config_en,
  output logic                                                  config_clk_en,
  output logic                                                  config_in,
  output logic                                                  expected_config_out,
  output logic [DATA_IN_WIRE_WIDTH-1:0]                         datain,
  output logic [DATA_OUT_WIRE_WIDTH-1:0]                        expected_dataout,
  output logic                                                  check_strobe,
  output logic                                                  busy,
  output logic                                                  sim_done
);

  localparam int BW = $clog2(CONFIG_WIDTH);
  localparam int VW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_VERIFY, S_APPLY, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_bit_cnt;
  logic [VW-1:0]   r_vec_cnt;
  logic [SW-1:0]   r_settle_cnt;
  logic            w_bit_last;
  logic            w_vec_last;
  logic            w_settle_last;

  assign w_bit_last    = (r_bit_cnt == BW'(CONFIG_WIDTH - 1));
  assign w_vec_last    = (r_vec_cnt == VW'(NUM_VECTORS - 1));
  assign w_settle_last = (r_settle_cnt == SW'(SETTLE_CYCLES - 1));

  // ROM addresses come straight from the counters so the data returns in the same cycle
  assign cfg_bit_addr = r_bit_cnt;
  assign vec_addr     = r_vec_cnt;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   if (w_bit_last) w_next = S_VERIFY;
      S_VERIFY: if (w_bit_last) w_next = S_APPLY;
      S_APPLY:  w_next = S_SETTLE;
      S_SETTLE: if (w_settle_last) w_next = S_CHECK;
      S_CHECK:  w_next = w_vec_last ? S_DONE : S_APPLY;
      S_DONE:   w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bit, vector and settle counters; each saturates or clears at its terminal value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt    <= '0;
      r_vec_cnt    <= '0;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:   r_bit_cnt <= '0;
        S_LOAD:   r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
        S_VERIFY: begin
          r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
          if (w_bit_last) r_vec_cnt <= '0;
        end
        S_APPLY:  r_settle_cnt <= '0;
        S_SETTLE: if (!w_settle_last) r_settle_cnt <= r_settle_cnt + 1'b1;
        S_CHECK:  if (!w_vec_last) r_vec_cnt <= r_vec_cnt + 1'b1;
        default:  ;
      endcase
    end
  end

  // Registered outputs, decoded from the current state so they lag the ROM addresses by one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      config_en           <= 1'b0;
      config_clk_en       <= 1'b0;
      config_in           <= 1'b0;
      expected_config_out <= 1'b0;
      datain              <= '0;
      expected_dataout    <= '0;
      check_strobe        <= 1'b0;
      busy                <= 1'b0;
      sim_done            <= 1'b0;
    end else begin
      config_en           <= 1'b0;
      config_clk_en       <= 1'b0;
      config_in           <= 1'b0;
      expected_config_out <= 1'b0;
      check_strobe        <= 1'b0;
      busy                <= 1'b0;
      case (r_state)
        S_LOAD: begin
          // chain starts from all zeros, so nothing shifts out yet
          config_en     <= 1'b1;
          config_clk_en <= 1'b1;
          config_in     <= cfg_bit_data;
          busy          <= 1'b1;
        end
        S_VERIFY: begin
          // recirculate: the bit leaving the chain is the one re-entering it
          config_en           <= 1'b1;
          config_clk_en       <= 1'b1;
          config_in           <= cfg_bit_data;
          expected_config_out <= cfg_bit_data;
          busy                <= 1'b1;
        end
        S_APPLY: begin
          datain           <= vec_datain;
          expected_dataout <= vec_expected;
          busy             <= 1'b1;
        end
        S_SETTLE: busy <= 1'b1;
        S_CHECK: begin
          check_strobe <= 1'b1;
          busy         <= 1'b1;
        end
        S_DONE:  sim_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_stim_driver.sv
// Directed bench for config_stim_driver: a nominal instance (CW=8, 3 vectors)
// and a minimum-parameter instance (CW=2, 1 vector, 1 settle cycle).
module tb_config_stim_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // ---------------- instance A: CW=8, NV=3, SETTLE=2 ----------------
  logic       resetn_a, start_a;
  logic [2:0] cfg_bit_addr_a;
  logic       cfg_bit_data_a;
  logic [1:0] vec_addr_a;
  logic [7:0] vec_datain_a, vec_expected_a;
  logic       config_en_a, config_clk_en_a, config_in_a, expected_config_out_a;
  logic [7:0] datain_a, expected_dataout_a;
  logic       check_strobe_a, busy_a, sim_done_a;

  logic [7:0] bs_a = 8'hB2;  // addr0..7 = 0,1,0,0,1,1,0,1
  logic [7:0] vin_a  [0:3];
  logic [7:0] vexp_a [0:3];
  initial begin
    vin_a[0] = 8'h05; vexp_a[0] = 8'h0A;
    vin_a[1] = 8'hFF; vexp_a[1] = 8'hFE;
    vin_a[2] = 8'h00; vexp_a[2] = 8'h00;
    vin_a[3] = 8'h77; vexp_a[3] = 8'h77;
  end
  assign cfg_bit_data_a = bs_a[cfg_bit_addr_a];
  assign vec_datain_a   = vin_a[vec_addr_a];
  assign vec_expected_a = vexp_a[vec_addr_a];

  config_stim_driver #(
    .DATA_IN_WIRE_WIDTH(8), .DATA_OUT_WIRE_WIDTH(8),
    .CONFIG_WIDTH(8), .NUM_VECTORS(3), .SETTLE_CYCLES(2)
  ) u_a (
    .clk(clk), .resetn(resetn_a), .start(start_a),
    .cfg_bit_addr(cfg_bit_addr_a), .cfg_bit_data(cfg_bit_data_a),
    .vec_addr(vec_addr_a), .vec_datain(vec_datain_a), .vec_expected(vec_expected_a),
    .config_en(config_en_a), .config_clk_en(config_clk_en_a),
    .config_in(config_in_a), .expected_config_out(expected_config_out_a),
    .datain(datain_a), .expected_dataout(expected_dataout_a),
    .check_strobe(check_strobe_a), .busy(busy_a), .sim_done(sim_done_a)
  );

  // ---------------- instance B: CW=2, NV=1, SETTLE=1 ----------------
  logic       resetn_b, start_b;
  logic [0:0] cfg_bit_addr_b;
  logic       cfg_bit_data_b;
  logic [0:0] vec_addr_b;
  logic [7:0] vec_datain_b, vec_expected_b;
  logic       config_en_b, config_clk_en_b, config_in_b, expected_config_out_b;
  logic [7:0] datain_b, expected_dataout_b;
  logic       check_strobe_b, busy_b, sim_done_b;

  logic [1:0] bs_b = 2'b10;  // addr0=0, addr1=1
  assign cfg_bit_data_b = bs_b[cfg_bit_addr_b];
  assign vec_datain_b   = 8'h3C;
  assign vec_expected_b = 8'hC3;

  config_stim_driver #(
    .DATA_IN_WIRE_WIDTH(8), .DATA_OUT_WIRE_WIDTH(8),
    .CONFIG_WIDTH(2), .NUM_VECTORS(1), .SETTLE_CYCLES(1)
  ) u_b (
    .clk(clk), .resetn(resetn_b), .start(start_b),
    .cfg_bit_addr(cfg_bit_addr_b), .cfg_bit_data(cfg_bit_data_b),
    .vec_addr(vec_addr_b), .vec_datain(vec_datain_b), .vec_expected(vec_expected_b),
    .config_en(config_en_b), .config_clk_en(config_clk_en_b),
    .config_in(config_in_b), .expected_config_out(expected_config_out_b),
    .datain(datain_b), .expected_dataout(expected_dataout_b),
    .check_strobe(check_strobe_b), .busy(busy_b), .sim_done(sim_done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_zero(input string pfx);
    chk({pfx, " config_en"},     32'(config_en_a), 0);
    chk({pfx, " config_clk_en"}, 32'(config_clk_en_a), 0);
    chk({pfx, " config_in"},     32'(config_in_a), 0);
    chk({pfx, " exp_cfg_out"},   32'(expected_config_out_a), 0);
    chk({pfx, " datain"},        32'(datain_a), 0);
    chk({pfx, " exp_dataout"},   32'(expected_dataout_a), 0);
    chk({pfx, " check_strobe"},  32'(check_strobe_a), 0);
    chk({pfx, " busy"},          32'(busy_a), 0);
    chk({pfx, " sim_done"},      32'(sim_done_a), 0);
    chk({pfx, " cfg_bit_addr"},  32'(cfg_bit_addr_a), 0);
  endtask

  // Full run on instance A; start must already be high so the next edge samples it.
  // k counts edges after the start-sampling edge.
  task automatic run_a(input string pfx);
    logic [7:0] e_din, e_dout;
    logic       e_in, e_xo;
    int unsigned e_addr, e_vaddr;
    step();  // edge 0: IDLE samples start
    for (int k = 1; k <= 29; k++) begin
      step();
      e_in   = (k <= 16) ? bs_a[(k - 1) % 8] : 1'b0;
      e_xo   = (k >= 9 && k <= 16) ? bs_a[k - 9] : 1'b0;
      e_addr = (k < 8) ? k : (k < 16) ? k - 8 : 0;
      e_vaddr = (k >= 24) ? 2 : (k >= 20) ? 1 : 0;
      if (k >= 25)      begin e_din = 8'h00; e_dout = 8'h00; end
      else if (k >= 21) begin e_din = 8'hFF; e_dout = 8'hFE; end
      else if (k >= 17) begin e_din = 8'h05; e_dout = 8'h0A; end
      else              begin e_din = 8'h00; e_dout = 8'h00; end
      chk($sformatf("%s k%0d config_clk_en", pfx, k), 32'(config_clk_en_a), 32'(k <= 16));
      chk($sformatf("%s k%0d config_en", pfx, k),     32'(config_en_a), 32'(k <= 16));
      chk($sformatf("%s k%0d config_in", pfx, k),     32'(config_in_a), 32'(e_in));
      chk($sformatf("%s k%0d exp_cfg_out", pfx, k),   32'(expected_config_out_a), 32'(e_xo));
      chk($sformatf("%s k%0d cfg_bit_addr", pfx, k),  32'(cfg_bit_addr_a), e_addr);
      chk($sformatf("%s k%0d vec_addr", pfx, k),      32'(vec_addr_a), e_vaddr);
      chk($sformatf("%s k%0d datain", pfx, k),        32'(datain_a), 32'(e_din));
      chk($sformatf("%s k%0d exp_dataout", pfx, k),   32'(expected_dataout_a), 32'(e_dout));
      chk($sformatf("%s k%0d check_strobe", pfx, k),  32'(check_strobe_a),
          32'(k == 20 || k == 24 || k == 28));
      chk($sformatf("%s k%0d busy", pfx, k),          32'(busy_a), 32'(k <= 28));
      chk($sformatf("%s k%0d sim_done", pfx, k),      32'(sim_done_a), 32'(k >= 29));
    end
  endtask

  initial begin
    resetn_a = 1'b0; start_a = 1'b0;
    resetn_b = 1'b0; start_b = 1'b0;
    #2;
    chk_a_zero("rst");
    step(); step();
    resetn_a = 1'b1;

    // idle with start low
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle busy", 32'(busy_a), 0);
      chk("idle config_clk_en", 32'(config_clk_en_a), 0);
    end

    // nominal run, start held high for the whole run and beyond
    start_a = 1'b1;
    run_a("run1");
    for (int i = 0; i < 6; i++) begin
      step();
      chk("done sim_done", 32'(sim_done_a), 1);
      chk("done config_clk_en", 32'(config_clk_en_a), 0);
      chk("done busy", 32'(busy_a), 0);
      chk("done check_strobe", 32'(check_strobe_a), 0);
      chk("done config_en", 32'(config_en_a), 0);
    end

    // reset out of DONE clears sim_done at once
    resetn_a = 1'b0;
    #1;
    chk("rst_done sim_done", 32'(sim_done_a), 0);
    #1;
    resetn_a = 1'b1;

    // abort mid-LOAD at bit 3
    step();  // edge 0 samples start
    for (int k = 1; k <= 3; k++) step();
    chk("midload cfg_bit_addr", 32'(cfg_bit_addr_a), 3);
    chk("midload config_clk_en", 32'(config_clk_en_a), 1);
    chk("midload busy", 32'(busy_a), 1);
    resetn_a = 1'b0;
    #1;
    chk_a_zero("abort");
    #1;
    resetn_a = 1'b1;
    run_a("run2");

    // minimum-parameter instance
    resetn_b = 1'b1;
    start_b  = 1'b1;
    step();  // edge 0 samples start
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("B k%0d config_clk_en", k), 32'(config_clk_en_b), 32'(k <= 4));
      chk($sformatf("B k%0d config_in", k), 32'(config_in_b),
          32'((k <= 4) ? bs_b[(k - 1) % 2] : 1'b0));
      chk($sformatf("B k%0d exp_cfg_out", k), 32'(expected_config_out_b),
          32'((k == 3 || k == 4) ? bs_b[k - 3] : 1'b0));
      chk($sformatf("B k%0d check_strobe", k), 32'(check_strobe_b), 32'(k == 7));
      chk($sformatf("B k%0d sim_done", k), 32'(sim_done_b), 32'(k >= 8));
      chk($sformatf("B k%0d busy", k), 32'(busy_b), 32'(k <= 7));
      chk($sformatf("B k%0d datain", k), 32'(datain_b), (k >= 5) ? 32'h3C : 32'h0);
      chk($sformatf("B k%0d exp_dataout", k), 32'(expected_dataout_b), (k >= 5) ? 32'hC3 : 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("B done sim_done", 32'(sim_done_b), 1);
      chk("B done config_clk_en", 32'(config_clk_en_b), 0);
      chk("B done check_strobe", 32'(check_strobe_b), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
